// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package adder_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Number of DIGIT-wide chunks in a WIDTH-wide operand.
    function automatic int unsigned num_chunks(input int unsigned width,
                                               input int unsigned digit);
        return width / digit;
    endfunction

    // Chunk counter width: enough to hold N-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Legal geometry: 1 <= DIGIT <= WIDTH and DIGIT divides WIDTH.
    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk_full_adder.sv
// DIGIT-bit combinational full adder slice used once per clock by the serial adder.
module chunk_full_adder #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign sum   = total[DIGIT-1:0];
    assign cout  = total[DIGIT];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, LSB chunk first.
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N    = num_chunks(WIDTH, DIGIT);
    localparam int unsigned CntW = cnt_width(N);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    if (!params_ok(WIDTH, DIGIT)) begin : gen_param_check
        $error("serial_chunk_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q;      // operand A, shifted right one chunk per RUN edge
    logic [WIDTH-1:0] b_q;      // B or ~B, shifted alongside a_q
    logic [WIDTH-1:0] res_q;    // partial result, filled from the top
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] res_next;
    logic             slice_ovf;

    chunk_full_adder #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Insert the new chunk at the MSB end; after N chunks the result is LSB-aligned.
    always_comb begin
        res_next = {slice_sum, res_q} >> DIGIT;
        // On the last chunk the slice top bits are the operand/result MSBs.
        slice_ovf = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1] ^ slice_cout;
    end

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    res_q   <= res_next;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sum     <= res_next;
                        cout    <= slice_cout;
                        ovf     <= slice_ovf;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
